mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, maximum consecutive data grants while a fetch waits; range 1..15.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port if_req  input  1  instruction-fetch request, held until if_ready.
REQ-007 SHALL have port if_addr  input  ADDR_W  fetch address, stable while if_req=1.
REQ-008 SHALL have port if_rdata  output  DATA_W  fetched instruction, valid when if_ready=1.
REQ-009 SHALL have port if_ready  output  1  one-cycle fetch completion pulse.
REQ-010 SHALL have port d_req  input  1  data-access request, held until d_ready.
REQ-011 SHALL have port d_we  input  1  data write enable, 1=store, 0=load.
REQ-012 SHALL have port d_addr  input  ADDR_W  data address.
REQ-013 SHALL have port d_wdata  input  DATA_W  store data.
REQ-014 SHALL have port d_rdata  output  DATA_W  load data, valid when d_ready=1.
REQ-015 SHALL have port d_ready  output  1  one-cycle data completion pulse.
REQ-016 SHALL have port m_req  output  1  shared-memory request, held until m_ack.
REQ-017 SHALL have ports m_we/m_addr/m_wdata  output  1/ADDR_W/DATA_W  registered memory command.
REQ-018 SHALL have port m_rdata  input  DATA_W  memory read data, valid with m_ack.
REQ-019 SHALL have port m_ack  input  1  memory completion, arbitrary latency >=0 cycles after m_req rises.
REQ-020 SHALL have port owner  output  1  current grant, 0=fetch, 1=data; valid while busy=1.
REQ-021 SHALL have port busy  output  1  high in BUSY and RESP states.

Function
REQ-022 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-023 IDLE: sample if_req/d_req; if any, select winner, register winner's addr/we/wdata into m_*, set owner, go BUSY; else stay IDLE.
REQ-024 Arbitration: data wins over fetch, except fetch wins when both request and streak==STARVE_MAX.
REQ-025 streak (4-bit) SHALL increment on a data grant while if_req=1, clear on a fetch grant or on any IDLE cycle with if_req=0, saturate at STARVE_MAX.
REQ-026 BUSY: m_req=1; on m_ack=1 capture m_rdata into owner's rdata register (loads and fetches only), go RESP.
REQ-027 RESP: pulse owner's ready for exactly one cycle, m_req=0, ignore requests, go IDLE.
REQ-028 Stores SHALL NOT modify d_rdata; d_ready still pulses.
REQ-029 Minimum latency: request in IDLE cycle N -> m_req cycle N+1 -> ready cycle N+2 when m_ack arrives in N+1; throughput one access per 3 cycles minimum.
REQ-030 m_ack outside BUSY SHALL be ignored.
REQ-031 m_addr/m_we/m_wdata SHALL stay stable for the whole BUSY period regardless of requester input changes.
REQ-032 Requester de-asserting req during BUSY SHALL NOT abort the access; ready still pulses.
REQ-033 d_we with d_req=0 SHALL be ignored.
REQ-034 if_ready and d_ready SHALL never be high in the same cycle.

Reset
REQ-035 rst=0 SHALL immediately force state IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, if_ready=0, d_ready=0, if_rdata=0, d_rdata=0, owner=0, busy=0, streak=0.
REQ-036 Reset during BUSY SHALL abandon the access with no ready pulse; a later m_ack SHALL be ignored.
REQ-037 First request is sampled on the first rising edge after rst returns to 1.

Verification
REQ-038 Single fetch: if_req=1, if_addr=0x0000_0040, m_ack one cycle after m_req with m_rdata=0x0050_0093 -> m_addr=0x40, m_we=0, if_ready pulse 2 cycles after request, if_rdata=0x0050_0093.
REQ-039 Simultaneous: if_req and d_req (load 0x100) both high -> data served first, owner=1; fetch served immediately after; d_ready precedes if_ready.
REQ-040 Starvation: if_req and d_req held continuously, STARVE_MAX=4 -> exactly 4 data grants then 1 fetch grant, pattern repeating.
REQ-041 Store: d_we=1, d_addr=0x200, d_wdata=0xDEAD_BEEF, d_rdata previously 0x1234 -> m_we=1, m_wdata=0xDEADBEEF, d_ready pulses, d_rdata stays 0x1234.
REQ-042 Slow memory: m_ack delayed 5 cycles, if_addr toggled mid-access -> m_req high 5 cycles, m_addr unchanged, single ready pulse.
REQ-043 Reset mid-access: rst=0 during BUSY, then m_ack after release -> all outputs 0 during reset, no ready pulse, FSM IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and data requesters onto one shared memory port with fetch anti-starvation
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              owner,
  output logic              busy
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic [1:0] state;
  logic [3:0] streak;
  logic       pick_d;
  // data wins unless the fetch has already waited out STARVE_MAX data grants
  assign pick_d   = d_req && !(if_req && streak == SMAX);
  assign m_req    = state == BUSY;
  assign busy     = state != IDLE;
  assign if_ready = state == RESP && !owner;
  assign d_ready  = state == RESP && owner;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      streak   <= '0;
      owner    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          streak <= (if_req && pick_d) ? streak + 4'd1 : 4'd0;
          if (if_req || d_req) begin
            state   <= BUSY;
            owner   <= pick_d;
            m_addr  <= pick_d ? d_addr : if_addr;
            m_we    <= pick_d && d_we;
            m_wdata <= pick_d ? d_wdata : '0;
          end
        end
        BUSY: begin
          if (m_ack) begin
            state <= RESP;
            if (!owner) if_rdata <= m_rdata;
            else if (!m_we) d_rdata <= m_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a transaction-level reference model
module tb_mem_arbiter;
  localparam int SMAX = 4;
  logic        clk, rst;
  logic        if_req, d_req, d_we, m_ack;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic        if_ready, d_ready, m_req, m_we, owner, busy;
  int checks = 0, errs = 0;
  int          ph, strk;
  logic        mo, mwe, dw;
  logic [31:0] ma, mwd, ird, drd;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .owner(owner), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  // Advance one clock: update the reference model from the inputs seen at the edge, then compare.
  task automatic tick();
    if (!rst) begin
      ph = 0; mo = 0; ird = 0; drd = 0; strk = 0;
    end else if (ph == 0) begin
      if (!if_req && !d_req) strk = 0;
      else begin
        dw   = d_req && !(if_req && strk == SMAX);
        strk = (dw && if_req) ? strk + 1 : 0;
        mo   = dw;
        ma   = dw ? d_addr : if_addr;
        mwe  = dw && d_we;
        mwd  = d_wdata;
        ph   = 1;
      end
    end else if (ph == 1) begin
      if (m_ack) begin
        if (!mo) ird = m_rdata;
        else if (!mwe) drd = m_rdata;
        ph = 2;
      end
    end else ph = 0;
    @(posedge clk);
    #1;
    chk1("busy", busy, ph != 0);
    chk1("m_req", m_req, ph == 1);
    chk1("if_ready", if_ready, ph == 2 && !mo);
    chk1("d_ready", d_ready, ph == 2 && mo);
    chk1("ready_excl", if_ready & d_ready, 1'b0);
    chk("if_rdata", if_rdata, ird);
    chk("d_rdata", d_rdata, drd);
    if (ph != 0) chk1("owner", owner, mo);
    if (ph == 1) begin
      chk("m_addr", m_addr, ma);
      chk1("m_we", m_we, mwe);
      if (mwe) chk("m_wdata", m_wdata, mwd);
    end
  endtask

  initial begin
    logic grants[$];
    int   mreq_n, rdy_n;
    rst = 0; if_req = 0; d_req = 0; d_we = 0; m_ack = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
    ph = 0; strk = 0; mo = 0; mwe = 0; ma = 0; mwd = 0; ird = 0; drd = 0;
    tick();
    tick();
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk1("rst_m_we", m_we, 1'b0);
    chk1("rst_owner", owner, 1'b0);
    rst = 1;
    // single fetch, issued right after reset release
    if_req = 1; if_addr = 32'h40;
    tick();
    chk("fetch_m_addr", m_addr, 32'h40);
    chk1("fetch_m_we", m_we, 1'b0);
    m_ack = 1; m_rdata = 32'h0050_0093;
    tick();
    chk1("fetch_ready", if_ready, 1'b1);
    chk("fetch_rdata", if_rdata, 32'h0050_0093);
    if_req = 0; m_ack = 0;
    tick();
    chk1("fetch_ready_once", if_ready, 1'b0);
    // seed d_rdata with a load, then store must leave it alone
    d_req = 1; d_we = 0; d_addr = 32'h100;
    tick();
    m_ack = 1; m_rdata = 32'h1234;
    tick();
    chk("load_rdata", d_rdata, 32'h1234);
    d_req = 0; m_ack = 0;
    tick();
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hdead_beef;
    tick();
    chk1("store_m_we", m_we, 1'b1);
    chk("store_m_wdata", m_wdata, 32'hdead_beef);
    chk("store_m_addr", m_addr, 32'h200);
    m_ack = 1; m_rdata = 32'hffff_ffff;
    tick();
    chk1("store_ready", d_ready, 1'b1);
    chk("store_keeps_rdata", d_rdata, 32'h1234);
    d_req = 0; d_we = 0; m_ack = 0;
    tick();
    // simultaneous: data first, fetch right after
    if_req = 1; if_addr = 32'h44; d_req = 1; d_addr = 32'h100;
    tick();
    chk1("simul_owner_d", owner, 1'b1);
    m_ack = 1; m_rdata = 32'h1111;
    tick();
    chk1("simul_d_first", d_ready, 1'b1);
    chk1("simul_if_later", if_ready, 1'b0);
    d_req = 0; m_ack = 0;
    tick();
    tick();
    chk1("simul_owner_f", owner, 1'b0);
    chk("simul_f_addr", m_addr, 32'h44);
    m_ack = 1; m_rdata = 32'h2222;
    tick();
    chk1("simul_if_ready", if_ready, 1'b1);
    if_req = 0; m_ack = 0;
    tick();
    // starvation: both held continuously
    if_req = 1; d_req = 1; d_we = 0;
    for (int c = 0; c < 80 && grants.size() < 10; c++) begin
      m_ack = m_req; m_rdata = $urandom;
      tick();
      if (d_ready) begin grants.push_back(1'b1); d_addr += 4; end
      if (if_ready) begin grants.push_back(1'b0); if_addr += 4; end
    end
    chk("starve_count", grants.size(), 32'd10);
    for (int k = 0; k < grants.size(); k++)
      chk1($sformatf("starve_grant_%0d", k), grants[k], (k % 5) != 4);
    if_req = 0; d_req = 0; m_ack = 1;
    tick(); tick(); tick();
    m_ack = 0;
    tick();
    // slow memory with address wiggling mid-access
    if_req = 1; if_addr = 32'h80;
    tick();
    mreq_n = 0; rdy_n = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_req) begin mreq_n++; chk("slow_m_addr", m_addr, 32'h80); end
      if (if_ready) begin rdy_n++; if_req = 0; end
      m_ack = (c == 4);
      if_addr = (c % 2 == 1) ? 32'h80 : 32'h84;
      tick();
    end
    chk("slow_m_req_cycles", mreq_n, 32'd5);
    chk("slow_ready_pulses", rdy_n, 32'd1);
    // reset during an in-flight load
    d_req = 1; d_we = 0; d_addr = 32'h300; m_ack = 0;
    tick();
    chk1("rstmid_busy", m_req, 1'b1);
    d_req = 0;
    #2 rst = 0;
    #1;
    chk1("rstmid_m_req", m_req, 1'b0);
    chk1("rstmid_busy0", busy, 1'b0);
    chk1("rstmid_owner", owner, 1'b0);
    chk1("rstmid_m_we", m_we, 1'b0);
    chk("rstmid_m_addr", m_addr, 32'h0);
    chk("rstmid_m_wdata", m_wdata, 32'h0);
    chk("rstmid_if_rdata", if_rdata, 32'h0);
    chk("rstmid_d_rdata", d_rdata, 32'h0);
    chk1("rstmid_d_ready", d_ready, 1'b0);
    tick();
    m_ack = 1;
    tick();
    rst = 1;
    tick();
    chk1("rstmid_no_ready_a", d_ready, 1'b0);
    tick();
    chk1("rstmid_no_ready_b", d_ready, 1'b0);
    m_ack = 0;
    tick();
    // randomized traffic, including stray acks and d_we toggling while idle
    for (int c = 0; c < 1500; c++) begin
      if (if_ready) begin if_req = 1'($urandom_range(0, 1)); if_addr = $urandom; end
      else if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1; if_addr = $urandom; end
      if (d_ready) begin
        d_req = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
        d_we = 1'($urandom_range(0, 1));
      end else if (!d_req) begin
        d_req = ($urandom_range(0, 2) == 0); d_addr = $urandom; d_wdata = $urandom;
        d_we = 1'($urandom_range(0, 1));
      end
      m_ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
      m_rdata = $urandom;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
